// File: rtl/traffic_pkg.sv
// Shared types and sizing helpers for the junction controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_ALL_RED = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Wide enough to hold 0..max_dur; the timer only ever reaches max_dur-1.
  function automatic int timer_width(input int max_dur);
    return $clog2(max_dur + 1);
  endfunction

endpackage

// File: rtl/traffic_rr_select.sv
// Round-robin search for the next approach to serve after cur_dir_i.
module traffic_rr_select #(
  parameter int NUM_DIR = 4,
  parameter int DW      = $clog2(NUM_DIR)
) (
  input  logic [DW-1:0]      cur_dir_i,
  input  logic [NUM_DIR-1:0] pend_i,
  input  logic               skip_idle_i,
  output logic [DW-1:0]      next_o,
  output logic               valid_o
);

  function automatic logic [DW-1:0] wrap_add(input logic [DW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_DIR) s = s - NUM_DIR;
    return DW'(s);
  endfunction

  logic [DW-1:0] idx;

  // Scan from the farthest offset down so the nearest pending approach wins.
  always_comb begin
    next_o  = cur_dir_i;
    valid_o = 1'b0;
    idx     = '0;
    if (!skip_idle_i) begin
      next_o  = wrap_add(cur_dir_i, 1);
      valid_o = 1'b1;
    end else begin
      for (int k = NUM_DIR - 1; k >= 1; k--) begin
        idx = wrap_add(cur_dir_i, k);
        if (pend_i[idx]) begin
          next_o  = idx;
          valid_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/traffic_junction_ctrl.sv
// N-approach junction controller: rotates green with demand latching,
// pedestrian early termination, idle-approach skipping and walk lamps.
module traffic_junction_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_DIR       = 4,
  parameter int GREEN_SEC     = 10,
  parameter int MIN_GREEN_SEC = 4,
  parameter int YELLOW_SEC    = 2,
  parameter int ALLRED_SEC    = 1,
  parameter int START_DIR     = 0,
  parameter bit SKIP_IDLE     = 1'b1,
  localparam int DW           = $clog2(NUM_DIR)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pulse_1s,
  input  logic [NUM_DIR-1:0] veh_req,
  input  logic [NUM_DIR-1:0] ped_req,
  output logic [NUM_DIR-1:0] red_light,
  output logic [NUM_DIR-1:0] yellow_light,
  output logic [NUM_DIR-1:0] green_light,
  output logic [NUM_DIR-1:0] walk,
  output logic [DW-1:0]      cur_dir,
  output logic [1:0]         state
);

  localparam int TW = timer_width(max3(GREEN_SEC, YELLOW_SEC, ALLRED_SEC));
  localparam logic [TW-1:0] GREEN_LAST  = TW'(GREEN_SEC - 1);
  localparam logic [TW-1:0] MIN_LAST    = TW'(MIN_GREEN_SEC - 1);
  localparam logic [TW-1:0] YELLOW_LAST = TW'(YELLOW_SEC - 1);
  localparam logic [TW-1:0] ALLRED_LAST = TW'(ALLRED_SEC - 1);
  localparam logic [DW-1:0] START_IDX   = DW'(START_DIR);

  state_e             state_q;
  logic [TW-1:0]      timer_q;
  logic [DW-1:0]      cur_dir_q, nxt_dir_q;
  logic [NUM_DIR-1:0] veh_pend_q, ped_pend_q;
  logic [NUM_DIR-1:0] veh_pend_d, ped_pend_d;
  logic               walk_en_q;

  logic [NUM_DIR-1:0] cur_oh, serving, pend_mask;
  logic               ped_other, green_done;
  logic [DW-1:0]      rr_next;
  logic               rr_valid;

  // The approach holding green ignores its own requests; everyone else latches.
  always_comb begin
    cur_oh            = '0;
    cur_oh[cur_dir_q] = 1'b1;
    serving           = (state_q == ST_GREEN) ? cur_oh : '0;
    veh_pend_d        = veh_pend_q | (veh_req & ~serving);
    ped_pend_d        = ped_pend_q | (ped_req & ~serving);
    pend_mask         = veh_pend_q | ped_pend_q;
    ped_other         = |(ped_pend_q & ~cur_oh);
    green_done        = pulse_1s &&
                        ((timer_q == GREEN_LAST) || ((timer_q >= MIN_LAST) && ped_other));
  end

  traffic_rr_select #(
    .NUM_DIR(NUM_DIR),
    .DW     (DW)
  ) u_rr_select (
    .cur_dir_i  (cur_dir_q),
    .pend_i     (pend_mask),
    .skip_idle_i(SKIP_IDLE),
    .next_o     (rr_next),
    .valid_o    (rr_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ALL_RED;
      timer_q    <= '0;
      cur_dir_q  <= START_IDX;
      nxt_dir_q  <= START_IDX;
      veh_pend_q <= '0;
      ped_pend_q <= '0;
      walk_en_q  <= 1'b0;
    end else begin
      veh_pend_q <= veh_pend_d;
      ped_pend_q <= ped_pend_d;
      if (pulse_1s) timer_q <= timer_q + 1'b1;
      case (state_q)
        ST_ALL_RED: begin
          if (pulse_1s && timer_q == ALLRED_LAST) begin
            state_q               <= ST_GREEN;
            timer_q               <= '0;
            cur_dir_q             <= nxt_dir_q;
            walk_en_q             <= ped_pend_q[nxt_dir_q] | ped_req[nxt_dir_q];
            veh_pend_q[nxt_dir_q] <= 1'b0;
            ped_pend_q[nxt_dir_q] <= 1'b0;
          end
        end
        ST_GREEN: begin
          // With no one else waiting, green is extended rather than ended.
          if (green_done) begin
            timer_q   <= '0;
            walk_en_q <= 1'b0;
            if (rr_valid) begin
              state_q   <= ST_YELLOW;
              nxt_dir_q <= rr_next;
            end
          end
        end
        ST_YELLOW: begin
          if (pulse_1s && timer_q == YELLOW_LAST) begin
            state_q <= ST_ALL_RED;
            timer_q <= '0;
          end
        end
        default: begin
          state_q <= ST_ALL_RED;
          timer_q <= '0;
        end
      endcase
    end
  end

  always_comb begin
    green_light  = '0;
    yellow_light = '0;
    walk         = '0;
    case (state_q)
      ST_GREEN: begin
        green_light = cur_oh;
        walk        = walk_en_q ? cur_oh : '0;
      end
      ST_YELLOW: yellow_light = cur_oh;
      default: ;
    endcase
    red_light = ~(green_light | yellow_light);
  end

  assign cur_dir = cur_dir_q;
  assign state   = state_q;

endmodule
